burst_arbiter: RTL and testbench
================================

# burst_arbiter

Two-requester round-robin controller that shares the single-port burst memory between two master FSMs. Each requester issues one burst command (read or write, 4-bit start address, 4-bit length). The block grants one requester at a time and sequences the burst one beat per cycle onto the memory port. It returns read data and write-beat strobes to the granted requester, then pulses done. It sits between the master FSMs and the slave/memory in the top-level interconnect.

## Interface
Parameters:
- DATA_W, 32, data width of memory and requester data ports
- ADDR_W, 4, address width; burst addresses wrap modulo 2^ADDR_W
- LEN_W, 4, burst length field width

Ports (n = 0, 1):
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- io_req_n_valid  in  1  requester n holds a command
- io_req_n_wr  in  1  1 = write burst, 0 = read burst
- io_req_n_address  in  ADDR_W  burst start address
- io_req_n_length  in  LEN_W  beat count; 0 = empty burst
- io_req_n_wdata  in  DATA_W  current write beat data
- io_req_n_ready  out  1  command accepted this cycle (valid & ready = handshake)
- io_req_n_wbeat  out  1  io_req_n_wdata consumed this cycle; requester advances to next beat
- io_req_n_rvalid  out  1  io_req_n_rdata holds a read beat
- io_req_n_rdata  out  DATA_W  read beat data
- io_req_n_done  out  1  one-cycle pulse, burst complete
- io_mem_en  out  1  memory access this cycle
- io_mem_we  out  1  write enable, qualified by io_mem_en
- io_mem_addr  out  ADDR_W  access address
- io_mem_wdata  out  DATA_W  write data
- io_mem_rdata  in  DATA_W  read data, valid one cycle after a read access

## Operation
- States: IDLE, BURST, DONE.
- IDLE:
  - Each ready is asserted only while that requester is selected by the round-robin pick.
  - Pick rule: if only one requester is valid, pick it. If both are valid, pick the one not granted last.
  - On handshake, latch grant index g, wr, address into the addr counter, and length into the remaining-beat counter.
  - If length = 0, go to DONE. Otherwise go to BURST.
- BURST, one beat per cycle:
  - io_mem_en = 1, io_mem_we = wr, io_mem_addr = addr.
  - On write: io_mem_wdata = io_req_g_wdata and io_req_g_wbeat = 1.
  - addr <= addr + 1, wrapping 4'hF -> 4'h0. Remaining beats decrement.
  - After the last beat, go to DONE.
- Read return: a delayed-enable register (1 cycle) drives io_req_g_rvalid. io_req_g_rdata = io_mem_rdata in that cycle.
- DONE: io_req_g_done = 1 for one cycle, last-grant pointer <= g, go to IDLE.
- Outputs to the non-granted requester stay 0 throughout a burst.
- A requester that drops valid before its handshake is simply not granted; no error is raised.
- Requester inputs are ignored outside handshake, except io_req_g_wdata during write beats.
- Reset values:
  - State IDLE, last-grant = 1, so requester 0 has priority first.
  - All counters 0.
  - Every output 0, except ready, which follows the IDLE pick rule in the same cycle.
- Reset asserted mid-burst: abort immediately. No done, rvalid or wbeat is asserted in the cycle after reset. Memory contents already written are left as they are.

## Timing
- Handshake at cycle t with length L > 0:
  - Memory beats k = 0..L-1 occur at t+1+k, addresses (A+k) mod 16.
  - Read rvalid occurs at t+2..t+L+1.
  - done occurs at t+L+1, coincident with the last read beat.
- Length 0: done at t+1; no memory access.
- Earliest next handshake is t+L+2. ready is never high outside IDLE.
- All outputs are registered or derived from state registers, with two exceptions:
  - ready is combinational from the valids and the last-grant pointer.
  - rdata is passed through from io_mem_rdata.

## Structure
- Package burst_pkg holds:
  - The state enum (IDLE, BURST, DONE).
  - The DATA_W, ADDR_W and LEN_W defaults.
  - The grant index type (1 bit).
- Sub-module rr_pick2 is combinational. Inputs: two valids and the last-grant bit. Outputs: a one-hot pick. It is reusable by later N-way variants.
- Everything else (beat counter, address counter, read-valid delay, output muxing) lives in burst_arbiter.

## Test plan
- Single write: req0 write A=7, L=4 with data A,B,C,D.
  - Expected: mem writes addr 7..A at t+1..t+4, four wbeat pulses, done at t+5.
- Read back: req1 read A=7, L=4.
  - Expected: rvalid t+2..t+5 with rdata A,B,C,D, done at t+5; req0 outputs stay 0.
- Contention: both valid in the same cycle from reset.
  - Expected: req0 granted first; req1 granted at the next IDLE.
  - Then both re-request: req0 is granted again only after req1 has been served (alternation).
- Wrap-around: write A=E, L=3.
  - Expected: addresses E, F, 0; done at t+4.
- Length 0: read L=0.
  - Expected: done at t+1, io_mem_en never high, no rvalid.
- Reset mid-burst: reset asserted at beat 2 of an L=8 burst.
  - Expected: next cycle IDLE, all outputs 0, no done; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared types and defaults for the two-requester burst arbiter.
// Grant index is a single bit: 0 = requester 0, 1 = requester 1.
package burst_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic gidx_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the side
// that was not granted last. Purely combinational, one-hot output.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = valid;
    if (valid == 2'b11) pick = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin arbiter that sequences one burst at a time, one beat per
// cycle, from either of two requesters onto a single-port memory.
module burst_arbiter
  import burst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_0_valid,
  input  logic              io_req_0_wr,
  input  logic [ADDR_W-1:0] io_req_0_address,
  input  logic [LEN_W-1:0]  io_req_0_length,
  input  logic [DATA_W-1:0] io_req_0_wdata,
  output logic              io_req_0_ready,
  output logic              io_req_0_wbeat,
  output logic              io_req_0_rvalid,
  output logic [DATA_W-1:0] io_req_0_rdata,
  output logic              io_req_0_done,
  input  logic              io_req_1_valid,
  input  logic              io_req_1_wr,
  input  logic [ADDR_W-1:0] io_req_1_address,
  input  logic [LEN_W-1:0]  io_req_1_length,
  input  logic [DATA_W-1:0] io_req_1_wdata,
  output logic              io_req_1_ready,
  output logic              io_req_1_wbeat,
  output logic              io_req_1_rvalid,
  output logic [DATA_W-1:0] io_req_1_rdata,
  output logic              io_req_1_done,
  output logic              io_mem_en,
  output logic              io_mem_we,
  output logic [ADDR_W-1:0] io_mem_addr,
  output logic [DATA_W-1:0] io_mem_wdata,
  input  logic [DATA_W-1:0] io_mem_rdata
);

  state_e            state_q, state_d;
  gidx_t             g_q, g_d;
  gidx_t             last_q, last_d;
  logic              wr_q, wr_d;
  logic              rvld_q, rvld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [1:0]        pick;

  rr_pick2 u_pick (
    .valid ({io_req_1_valid, io_req_0_valid}),
    .last  (last_q),
    .pick  (pick)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rvld_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          g_d     = gidx_t'(pick[1]);
          wr_d    = pick[1] ? io_req_1_wr      : io_req_0_wr;
          addr_d  = pick[1] ? io_req_1_address : io_req_0_address;
          rem_d   = pick[1] ? io_req_1_length  : io_req_0_length;
          state_d = (rem_d == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        // Address wraps naturally at the counter width.
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - LEN_W'(1);
        rvld_d = ~wr_q;
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        last_d  = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
      rvld_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rvld_q  <= rvld_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  logic in_burst, in_done, wbeat;
  assign in_burst = (state_q == BURST);
  assign in_done  = (state_q == DONE);
  assign wbeat    = in_burst & wr_q;

  assign io_req_0_ready  = (state_q == IDLE) & pick[0];
  assign io_req_1_ready  = (state_q == IDLE) & pick[1];

  assign io_mem_en    = in_burst;
  assign io_mem_we    = wbeat;
  assign io_mem_addr  = in_burst ? addr_q : '0;
  assign io_mem_wdata = wbeat ? (g_q ? io_req_1_wdata : io_req_0_wdata) : '0;

  // The non-granted side sees all zeros, including read data.
  assign io_req_0_wbeat  = wbeat & ~g_q;
  assign io_req_1_wbeat  = wbeat &  g_q;
  assign io_req_0_rvalid = rvld_q & ~g_q;
  assign io_req_1_rvalid = rvld_q &  g_q;
  assign io_req_0_rdata  = io_req_0_rvalid ? io_mem_rdata : '0;
  assign io_req_1_rdata  = io_req_1_rvalid ? io_mem_rdata : '0;
  assign io_req_0_done   = in_done & ~g_q;
  assign io_req_1_done   = in_done &  g_q;

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed bench for burst_arbiter: a cycle-indexed burst model predicts
// every output each cycle; literal checks pin latencies, grants and memory.
module tb_burst_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic v [2];
  logic wr [2];
  logic [AW-1:0] ad [2];
  logic [LW-1:0] ln [2];
  logic [DW-1:0] wd [2];
  logic rdy0, rdy1, wb0, wb1, rv0, rv1, dn0, dn1;
  logic [DW-1:0] rd0, rd1;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [16] = '{default: '0};
  int wcnt [2] = '{0, 0};
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  burst_arbiter dut (
    .clock(clock), .reset(reset),
    .io_req_0_valid(v[0]), .io_req_0_wr(wr[0]), .io_req_0_address(ad[0]),
    .io_req_0_length(ln[0]), .io_req_0_wdata(wd[0]), .io_req_0_ready(rdy0),
    .io_req_0_wbeat(wb0), .io_req_0_rvalid(rv0), .io_req_0_rdata(rd0), .io_req_0_done(dn0),
    .io_req_1_valid(v[1]), .io_req_1_wr(wr[1]), .io_req_1_address(ad[1]),
    .io_req_1_length(ln[1]), .io_req_1_wdata(wd[1]), .io_req_1_ready(rdy1),
    .io_req_1_wbeat(wb1), .io_req_1_rvalid(rv1), .io_req_1_rdata(rd1), .io_req_1_done(dn1),
    .io_mem_en(mem_en), .io_mem_we(mem_we), .io_mem_addr(mem_addr),
    .io_mem_wdata(mem_wdata), .io_mem_rdata(mem_rdata)
  );

  // Write data stream per requester; the i-th write beat of requester r.
  function automatic logic [DW-1:0] wdat(input int r, input int i);
    if (r == 0) return (i < 4) ? DW'(32'hA + i) : DW'(32'h100 + i);
    return DW'(32'h200 + i);
  endfunction

  assign wd[0] = wdat(0, wcnt[0]);
  assign wd[1] = wdat(1, wcnt[1]);

  // Requesters advance on wbeat; memory reads return one cycle later.
  always @(posedge clock) begin
    if (wb0) wcnt[0] <= wcnt[0] + 1;
    if (wb1) wcnt[1] <= wcnt[1] + 1;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mpick(input logic a, input logic b, input int last);
    if (a && b) return (last == 1) ? 2'b01 : 2'b10;
    return {b, a};
  endfunction

  // Model: a burst handshaken at cycle hs with length ml owns cycles
  // hs+1..hs+ml+1; beats at hs+1+k, read returns one cycle later, done last.
  bit busy = 1'b0;
  int hs, mg, ma, ml, cyc = 0;
  int mlast = 1;
  bit mwr;
  int mwc [2] = '{0, 0};
  logic [DW-1:0] em [16] = '{default: '0};
  int glog [$];

  always @(negedge clock) begin
    logic [1:0] er, ewb, erv, edn;
    logic een, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd, erd;
    bit idle;
    er = '0; ewb = '0; erv = '0; edn = '0;
    een = 1'b0; ewe = 1'b0; eaddr = '0; ewd = '0; erd = '0;
    idle = !(busy && cyc <= hs + ml + 1);
    if (idle) er = mpick(v[0], v[1], mlast);
    if (busy && cyc >= hs + 1 && cyc <= hs + ml) begin
      een = 1'b1;
      ewe = mwr;
      eaddr = AW'((ma + cyc - hs - 1) % 16);
      if (mwr) begin
        ewd = wdat(mg, mwc[mg]);
        ewb[mg] = 1'b1;
        em[eaddr] = ewd;
        mwc[mg]++;
      end
    end
    if (busy && !mwr && cyc >= hs + 2 && cyc <= hs + ml + 1) begin
      erv[mg] = 1'b1;
      erd = em[(ma + cyc - hs - 2) % 16];
    end
    if (busy && cyc == hs + ml + 1) edn[mg] = 1'b1;

    chk("ready", DW'({rdy1, rdy0}), DW'(er));
    chk("mem_en", DW'(mem_en), DW'(een));
    chk("wbeat", DW'({wb1, wb0}), DW'(ewb));
    chk("rvalid", DW'({rv1, rv0}), DW'(erv));
    chk("done", DW'({dn1, dn0}), DW'(edn));
    if (een) begin
      chk("mem_we", DW'(mem_we), DW'(ewe));
      chk("mem_addr", DW'(mem_addr), DW'(eaddr));
      if (ewe) chk("mem_wdata", mem_wdata, ewd);
    end
    if (erv[0]) chk("rdata0", rd0, erd);
    if (erv[1]) chk("rdata1", rd1, erd);

    if (rdy0 && v[0] && !reset) glog.push_back(0);
    if (rdy1 && v[1] && !reset) glog.push_back(1);

    if (edn != 2'b00) mlast = mg;
    if (reset) begin
      busy = 1'b0;
      mlast = 1;
    end else if (er != 2'b00) begin
      busy = 1'b1;
      hs = cyc;
      mg = er[1] ? 1 : 0;
      mwr = wr[mg];
      ma = int'(ad[mg]);
      ml = int'(ln[mg]);
    end
    cyc++;
  end

  // Issue one command and return cycles from handshake to done (0 = timeout).
  task automatic send(input int r, input bit w, input int a, input int l, output int lat);
    bit ok;
    @(posedge clock); #1;
    wr[r] = w; ad[r] = AW'(a); ln[r] = LW'(l); v[r] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      ok = (r == 1) ? rdy1 : rdy0;
    end
    lat = 0;
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL handshake_timeout: requester %0d got no ready, required ready within 50 cycles", r);
      v[r] = 1'b0;
      return;
    end
    @(posedge clock); #1;
    v[r] = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clock);
      if ((r == 1) ? dn1 : dn0) begin
        lat = t;
        break;
      end
    end
  endtask

  initial begin
    int lat, l0a, l0b, l1, base;
    bit ok;
    v[0] = 0; v[1] = 0; wr[0] = 0; wr[1] = 0;
    ad[0] = '0; ad[1] = '0; ln[0] = '0; ln[1] = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_idle_mem_en", DW'(mem_en), '0);
    chk("reset_done", DW'({dn1, dn0}), '0);

    // Single write: addresses 7..A, data A..D
    send(0, 1'b1, 7, 4, lat);
    chk("write_latency", DW'(lat), DW'(5));
    chk("mem7", mem[7], DW'(32'hA));
    chk("mem8", mem[8], DW'(32'hB));
    chk("mem9", mem[9], DW'(32'hC));
    chk("memA", mem[10], DW'(32'hD));

    // Read back by requester 1
    send(1, 1'b0, 7, 4, lat);
    chk("read_latency", DW'(lat), DW'(5));

    // Contention: req0 re-requests while req1 waits; grants must alternate
    base = glog.size();
    fork
      begin send(0, 1'b0, 7, 2, l0a); send(0, 1'b0, 9, 1, l0b); end
      begin send(1, 1'b0, 8, 2, l1); end
    join
    chk("contend_count", DW'(glog.size() - base), DW'(3));
    if (glog.size() >= base + 3) begin
      chk("contend_g0", DW'(glog[base]), DW'(0));
      chk("contend_g1", DW'(glog[base + 1]), DW'(1));
      chk("contend_g2", DW'(glog[base + 2]), DW'(0));
    end
    chk("contend_lat1", DW'(l1), DW'(3));

    // Wrap-around write E, F, 0
    send(0, 1'b1, 14, 3, lat);
    chk("wrap_latency", DW'(lat), DW'(4));
    chk("memE", mem[14], DW'(32'h104));
    chk("memF", mem[15], DW'(32'h105));
    chk("mem0", mem[0], DW'(32'h106));

    // Empty burst
    send(1, 1'b0, 5, 0, lat);
    chk("len0_latency", DW'(lat), DW'(1));

    // Reset during beat 2 of an 8-beat write
    @(posedge clock); #1;
    wr[1] = 1'b1; ad[1] = AW'(2); ln[1] = LW'(8); v[1] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clock);
      ok = rdy1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL abort_handshake: got no ready, required ready within 50 cycles");
    end
    @(posedge clock); #1 v[1] = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_done", DW'({dn1, dn0}), '0);
    chk("abort_mem_en", DW'(mem_en), '0);
    chk("abort_wbeat", DW'({wb1, wb0}), '0);
    chk("abort_rvalid", DW'({rv1, rv0}), '0);
    chk("mem2", mem[2], DW'(32'h200));
    chk("mem3", mem[3], DW'(32'h201));
    chk("mem4", mem[4], DW'(32'h202));
    chk("mem5", mem[5], '0);
    send(0, 1'b0, 2, 3, lat);
    chk("post_reset_latency", DW'(lat), DW'(4));

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
